// File: rtl/mips_core_pkg.sv
// Shared types for the MIPS out-of-order core: ROB tag/data widths, CDB requester ids
// and the {tag, data} entry carried by the common data bus.
`ifndef ROB_DEPTH_BITS
`define ROB_DEPTH_BITS 6
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;

  localparam int ROB_DEPTH_BITS = `ROB_DEPTH_BITS;
  localparam int DATA_WIDTH     = `DATA_WIDTH;
  localparam int NUM_CDB_REQ    = 3;

  typedef enum logic [1:0] {
    CDB_REQ_ALU    = 2'd0,
    CDB_REQ_LOAD   = 2'd1,
    CDB_REQ_BRANCH = 2'd2
  } CdbReqId;

  typedef struct packed {
    logic [ROB_DEPTH_BITS-1:0] tag;
    logic [DATA_WIDTH-1:0]     data;
  } CdbEntry;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side handshake bundle (one lane per requester) and the common data bus
// broadcast bundle driven by the arbiter.
interface cdb_arbiter_if
  import mips_core_pkg::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ
) ();

  logic [NUM_REQ-1:0]                     req_valid;
  logic [NUM_REQ-1:0][ROB_DEPTH_BITS-1:0] req_tag;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_data;
  logic [NUM_REQ-1:0]                     req_ready;

  modport master (
    output req_valid,
    output req_tag,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_tag,
    input  req_data,
    output req_ready
  );

endinterface

interface common_data_bus_ifc
  import mips_core_pkg::*;
();

  logic                      cdb_valid;
  logic [ROB_DEPTH_BITS-1:0] cdb_tag;
  logic [DATA_WIDTH-1:0]     cdb_data;

  modport master (
    output cdb_valid,
    output cdb_tag,
    output cdb_data
  );

  modport slave (
    input cdb_valid,
    input cdb_tag,
    input cdb_data
  );

endinterface

// File: rtl/cdb_req_fifo.sv
// Per-requester holding buffer: small circular FIFO with a registered ready flag
// derived purely from occupancy, so ready never depends combinationally on inputs.
module cdb_req_fifo
  import mips_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  logic    push,
  input  logic    pop,
  input  CdbEntry din,
  output CdbEntry dout,
  output logic    ready,
  output logic    not_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  CdbEntry          entry_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             ready_reg;
  logic             do_push;
  logic             do_pop;

  // A held request on a full buffer is simply not consumed; the requester keeps it.
  assign do_push = push && ready_reg && !flush;
  assign do_pop  = pop && (count_reg != '0) && !flush;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
    if (flush) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b1;
    end else begin
      count_reg <= count_next;
      ready_reg <= (count_next < CNT_W'(DEPTH));
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (do_push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (do_pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      entry_mem[wr_ptr_reg] <= din;
    end
  end

  assign dout      = entry_mem[rd_ptr_reg];
  assign ready     = ready_reg;
  assign not_empty = (count_reg != '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results per requester, picks one per cycle in
// round-robin order and broadcasts it from a registered output stage.
module cdb_arbiter
  import mips_core_pkg::*;
#(
  parameter int NUM_REQ   = NUM_CDB_REQ,
  parameter int BUF_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  cdb_arbiter_if.slave       req,
  common_data_bus_ifc.master cdb,
  output logic [1:0] cdb_src
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  CdbEntry            push_entry [NUM_REQ];
  CdbEntry            head       [NUM_REQ];
  logic [NUM_REQ-1:0] not_empty;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] ready_vec;

  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   rr_ptr_next;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic               grant_valid;

  logic               cdb_valid_reg;
  CdbEntry            cdb_entry_reg;
  logic [1:0]         cdb_src_reg;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign push_entry[gi] = {req.req_tag[gi], req.req_data[gi]};
      assign pop[gi]        = grant_valid && (grant_idx == IDX_W'(gi));

      cdb_req_fifo #(
        .DEPTH (BUF_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (req.req_valid[gi]),
        .pop       (pop[gi]),
        .din       (push_entry[gi]),
        .dout      (head[gi]),
        .ready     (ready_vec[gi]),
        .not_empty (not_empty[gi])
      );
    end
  endgenerate

  assign req.req_ready = ready_vec;

  // First non-empty buffer at or after rr_ptr, wrapping from NUM_REQ-1 back to 0.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (!grant_valid && not_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) begin
      rr_ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Idle cycles drop cdb_valid but keep the last tag/data/src on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      cdb_valid_reg <= 1'b0;
      cdb_entry_reg <= '0;
      cdb_src_reg   <= '0;
    end else if (flush) begin
      rr_ptr_reg    <= '0;
      cdb_valid_reg <= 1'b0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      cdb_valid_reg <= grant_valid;
      if (grant_valid) begin
        cdb_entry_reg <= head[grant_idx];
        cdb_src_reg   <= 2'(grant_idx);
      end
    end
  end

  assign cdb.cdb_valid = cdb_valid_reg;
  assign cdb.cdb_tag   = cdb_entry_reg.tag;
  assign cdb.cdb_data  = cdb_entry_reg.data;
  assign cdb_src       = cdb_src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a table of per-cycle stimulus rows with
// hand-computed bus/ready expectations, plus single-request and async-reset sequences.
module tb_cdb_arbiter;
  import mips_core_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] cdb_src;

  cdb_arbiter_if #(.NUM_REQ(3)) req_if ();
  common_data_bus_ifc bus_if ();

  cdb_arbiter #(
    .NUM_REQ   (3),
    .BUF_DEPTH (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .req     (req_if),
    .cdb     (bus_if),
    .cdb_src (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic       fl;
    logic [2:0] vld;
    logic [5:0] t0;
    logic [5:0] t1;
    logic [5:0] t2;
    logic       ev;
    logic [5:0] etag;
    logic [1:0] esrc;
    logic [2:0] erdy;
  } vec_t;

  vec_t vecs[$];

  task automatic check_value(input string name, input logic [63:0] got, input logic [63:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] data_of(input int src, input logic [5:0] tag);
    return 32'hC0DE_0000 | (32'(src) << 8) | 32'(tag);
  endfunction

  task automatic add(input logic fl, input logic [2:0] vld, input logic [5:0] t0,
                     input logic [5:0] t1, input logic [5:0] t2, input logic ev,
                     input logic [5:0] etag, input logic [1:0] esrc, input logic [2:0] erdy);
    vec_t v;
    v.fl = fl; v.vld = vld; v.t0 = t0; v.t1 = t1; v.t2 = t2;
    v.ev = ev; v.etag = etag; v.esrc = esrc; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush            = 1'b0;
    req_if.req_valid = '0;
    req_if.req_tag   = '0;
    req_if.req_data  = '0;
  endtask

  task automatic drive_push(input int idx, input logic [5:0] tag, input logic [31:0] data);
    req_if.req_valid[idx] = 1'b1;
    req_if.req_tag[idx]   = tag;
    req_if.req_data[idx]  = data;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    drive_idle();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_valid", 64'(bus_if.cdb_valid), 64'd0);
    check_value("rst_tag",   64'(bus_if.cdb_tag),   64'd0);
    check_value("rst_data",  64'(bus_if.cdb_data),  64'd0);
    check_value("rst_src",   64'(cdb_src),          64'd0);
    check_value("rst_ready", 64'(req_if.req_ready), 64'b111);
    #3 rst_n = 1'b1;

    // Single ALU request
    drive_push(CDB_REQ_ALU, 6'd5, 32'hDEAD_BEEF);
    tick();
    drive_idle();
    check_value("single_nobypass", 64'(bus_if.cdb_valid), 64'd0);
    tick();
    $display("single: valid=%0b tag=%0d data=%h src=%0d", bus_if.cdb_valid, bus_if.cdb_tag, bus_if.cdb_data, cdb_src);
    check_value("single_valid", 64'(bus_if.cdb_valid), 64'd1);
    check_value("single_tag",   64'(bus_if.cdb_tag),   64'd5);
    check_value("single_data",  64'(bus_if.cdb_data),  64'hDEAD_BEEF);
    check_value("single_src",   64'(cdb_src),          64'd0);
    tick();
    check_value("single_idle_valid", 64'(bus_if.cdb_valid), 64'd0);
    check_value("single_hold_data",  64'(bus_if.cdb_data),  64'hDEAD_BEEF);
    check_value("single_hold_tag",   64'(bus_if.cdb_tag),   64'd5);

    // Three-way contention (flush first to put rr_ptr at 0), then rr_ptr=0 probe
    add(1, 3'b000,  0,  0,  0, 0,  0, 0, 3'b111);
    add(0, 3'b111,  1,  2,  3, 0,  0, 0, 3'b111);
    add(0, 3'b000,  0,  0,  0, 1,  1, 0, 3'b111);
    add(0, 3'b000,  0,  0,  0, 1,  2, 1, 3'b111);
    add(0, 3'b000,  0,  0,  0, 1,  3, 2, 3'b111);
    add(0, 3'b000,  0,  0,  0, 0,  0, 0, 3'b111);
    add(0, 3'b101, 11,  0, 13, 0,  0, 0, 3'b111);
    add(0, 3'b000,  0,  0,  0, 1, 11, 0, 3'b111);
    add(0, 3'b000,  0,  0,  0, 1, 13, 2, 3'b111);
    add(0, 3'b000,  0,  0,  0, 0,  0, 0, 3'b111);
    // Fairness: load streams, ALU pushes one result
    add(0, 3'b010,  0, 40,  0, 0,  0, 0, 3'b111);
    add(0, 3'b010,  0, 41,  0, 1, 40, 1, 3'b111);
    add(0, 3'b011, 50, 42,  0, 1, 41, 1, 3'b111);
    add(0, 3'b010,  0, 43,  0, 1, 50, 0, 3'b101);
    add(0, 3'b010,  0, 44,  0, 1, 42, 1, 3'b111);
    add(0, 3'b010,  0, 44,  0, 1, 43, 1, 3'b111);
    add(0, 3'b000,  0,  0,  0, 1, 44, 1, 3'b111);
    // Backpressure on the branch unit
    add(0, 3'b111, 60, 61, 70, 0,  0, 0, 3'b111);
    add(0, 3'b100,  0,  0, 71, 1, 70, 2, 3'b111);
    add(0, 3'b100,  0,  0, 72, 1, 60, 0, 3'b011);
    add(0, 3'b100,  0,  0, 73, 1, 61, 1, 3'b011);
    add(0, 3'b100,  0,  0, 73, 1, 71, 2, 3'b111);
    add(0, 3'b100,  0,  0, 73, 1, 72, 2, 3'b111);
    add(0, 3'b000,  0,  0,  0, 1, 73, 2, 3'b111);
    // Flush with buffers loaded and cdb_valid high; same-cycle pushes dropped
    add(0, 3'b111, 20, 21, 22, 0,  0, 0, 3'b111);
    add(0, 3'b111, 23, 24, 25, 1, 20, 0, 3'b001);
    add(1, 3'b111, 26, 27, 28, 0,  0, 0, 3'b111);
    add(0, 3'b000,  0,  0,  0, 0,  0, 0, 3'b111);
    add(0, 3'b000,  0,  0,  0, 0,  0, 0, 3'b111);
    add(0, 3'b000,  0,  0,  0, 0,  0, 0, 3'b111);
    add(0, 3'b110,  0, 30, 31, 0,  0, 0, 3'b111);
    add(0, 3'b000,  0,  0,  0, 1, 30, 1, 3'b111);
    add(0, 3'b000,  0,  0,  0, 1, 31, 2, 3'b111);
    add(0, 3'b000,  0,  0,  0, 0,  0, 0, 3'b111);

    for (int r = 0; r < vecs.size(); r++) begin
      drive_idle();
      flush = vecs[r].fl;
      if (vecs[r].vld[0]) drive_push(0, vecs[r].t0, data_of(0, vecs[r].t0));
      if (vecs[r].vld[1]) drive_push(1, vecs[r].t1, data_of(1, vecs[r].t1));
      if (vecs[r].vld[2]) drive_push(2, vecs[r].t2, data_of(2, vecs[r].t2));
      tick();
      $display("vec %0d: valid=%0b tag=%0d src=%0d ready=%b", r, bus_if.cdb_valid, bus_if.cdb_tag, cdb_src, req_if.req_ready);
      check_value($sformatf("vec%0d_valid", r), 64'(bus_if.cdb_valid), 64'(vecs[r].ev));
      check_value($sformatf("vec%0d_ready", r), 64'(req_if.req_ready), 64'(vecs[r].erdy));
      if (vecs[r].ev) begin
        check_value($sformatf("vec%0d_tag", r),  64'(bus_if.cdb_tag),  64'(vecs[r].etag));
        check_value($sformatf("vec%0d_src", r),  64'(cdb_src),         64'(vecs[r].esrc));
        check_value($sformatf("vec%0d_data", r), 64'(bus_if.cdb_data), 64'(data_of(int'(vecs[r].esrc), vecs[r].etag)));
      end
    end
    drive_idle();

    // Asynchronous reset mid-stream
    drive_push(0, 6'd9, data_of(0, 6'd9));
    drive_push(1, 6'd10, data_of(1, 6'd10));
    tick();
    drive_idle();
    tick();
    check_value("pre_rst_valid", 64'(bus_if.cdb_valid), 64'd1);
    check_value("pre_rst_tag",   64'(bus_if.cdb_tag),   64'd9);
    #3 rst_n = 1'b0;
    #1;
    $display("async reset: valid=%0b tag=%0d data=%h src=%0d", bus_if.cdb_valid, bus_if.cdb_tag, bus_if.cdb_data, cdb_src);
    check_value("arst_valid", 64'(bus_if.cdb_valid), 64'd0);
    check_value("arst_tag",   64'(bus_if.cdb_tag),   64'd0);
    check_value("arst_data",  64'(bus_if.cdb_data),  64'd0);
    check_value("arst_src",   64'(cdb_src),          64'd0);
    check_value("arst_ready", 64'(req_if.req_ready), 64'b111);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check_value("post_rst_discard", 64'(bus_if.cdb_valid), 64'd0);
    drive_push(0, 6'd7, data_of(0, 6'd7));
    tick();
    drive_idle();
    check_value("post_rst_nobypass", 64'(bus_if.cdb_valid), 64'd0);
    tick();
    $display("post reset: valid=%0b tag=%0d data=%h src=%0d", bus_if.cdb_valid, bus_if.cdb_tag, bus_if.cdb_data, cdb_src);
    check_value("post_rst_valid", 64'(bus_if.cdb_valid), 64'd1);
    check_value("post_rst_tag",   64'(bus_if.cdb_tag),   64'd7);
    check_value("post_rst_data",  64'(bus_if.cdb_data),  64'(data_of(0, 6'd7)));
    check_value("post_rst_src",   64'(cdb_src),          64'd0);
    tick();
    check_value("post_rst_idle", 64'(bus_if.cdb_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3; number of requesters sharing the common data bus (0 = ALU, 1 = load unit, 2 = branch unit).
REQ-002 Parameter BUF_DEPTH, default 2; entries per requester holding buffer, power of two, at least 2.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- flush, in, 1: synchronous; discards all buffered and in-flight results.
- req_valid, in, NUM_REQ: per-requester result valid.
- req_tag, in, NUM_REQ x `ROB_DEPTH_BITS: per-requester ROB tag.
- req_data, in, NUM_REQ x `DATA_WIDTH: per-requester result value.
- req_ready, out, NUM_REQ: per-requester buffer can accept this cycle.
- cdb_valid, out, 1: bus carries a result.
- cdb_tag, out, `ROB_DEPTH_BITS: broadcast tag.
- cdb_data, out, `DATA_WIDTH: broadcast value.
- cdb_src, out, 2: index of the requester whose result is on the bus.

Function
REQ-004 A request is accepted when req_valid[i] and req_ready[i] are both high on a rising edge; the {tag, data} pair is written to the tail of buffer i.
REQ-005 req_ready[i] SHALL be a registered function of buffer occupancy only: high when count[i] < BUF_DEPTH; no combinational path from any input.
REQ-006 Each cycle, among non-empty buffers, the arbiter grants the first index at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
REQ-007 On a grant, the head of the winning buffer is popped, and cdb_valid=1, cdb_tag, cdb_data and cdb_src are registered at the next edge.
REQ-008 When no buffer is non-empty, cdb_valid is registered to 0; cdb_tag, cdb_data and cdb_src hold their previous values.
REQ-009 After a grant to index w, rr_ptr becomes (w+1) mod NUM_REQ; with no grant, rr_ptr is unchanged.
REQ-010 Latency: a request accepted at edge k appears on the bus no earlier than the cycle after edge k+1; there is no bypass from input to bus.
REQ-011 At most one result is broadcast per cycle; results from the same requester appear in acceptance order.
REQ-012 Simultaneous push and pop on the same buffer is allowed in one cycle; count is unchanged and data is preserved.
REQ-013 Buffer pointers wrap modulo BUF_DEPTH; count ranges from 0 to BUF_DEPTH and never overflows or underflows.
REQ-014 flush has priority over all other activity: at the edge it is sampled, all counts, pointers and rr_ptr are cleared to 0, cdb_valid is cleared to 0, and that cycle's pushes are dropped.
REQ-015 When a buffer is full and its requester holds req_valid high, the request is not accepted and the requester's inputs are not consumed.

Reset
REQ-016 rst_n low asynchronously forces the following to 0: all buffer counts and pointers, rr_ptr, cdb_valid, cdb_tag, cdb_data and cdb_src.
REQ-017 During reset req_ready is all-ones, consistent with empty buffers. Reset asserted mid-operation discards all buffered results without broadcasting them.

Structure
REQ-018 The shared package mips_core_pkg SHALL hold:
- constant NUM_CDB_REQ = 3;
- enum CdbReqId {CDB_REQ_ALU=0, CDB_REQ_LOAD=1, CDB_REQ_BRANCH=2};
- packed struct CdbEntry {tag, data}.
REQ-019 The per-requester buffer is sub-module cdb_req_fifo, instantiated NUM_REQ times. The round-robin pick and the output register live in cdb_arbiter.
REQ-020 The output drives a common_data_bus_ifc instance; cdb_src is a side signal.

Verification
REQ-021 Single request: ALU pushes tag=5, data=0xDEAD_BEEF at edge 1 -> cdb_valid=1, tag=5, data=0xDEADBEEF, src=0 after edge 2; cdb_valid=0 after edge 3.
REQ-022 Three-way contention: all three requesters push in the same cycle with tags 1, 2, 3 and rr_ptr=0 -> bus order is tags 1, 2, 3 on consecutive cycles, and rr_ptr ends at 0.
REQ-023 Fairness: the load unit streams continuously while the ALU pushes one result -> the ALU result is broadcast within 2 cycles of becoming the buffer head; the load unit never wins twice while the ALU buffer is non-empty.
REQ-024 Backpressure: 3 pushes to the branch unit with no pops possible -> req_ready[2]=0 after 2 accepted; the third is held and accepted once one pop frees space; order is preserved.
REQ-025 Flush with 2 entries buffered in each requester and cdb_valid=1 -> next cycle cdb_valid=0, all req_ready=1, and no stale tag is ever broadcast afterward.
REQ-026 Asynchronous reset mid-stream: rst_n asserted between clock edges -> outputs are 0 immediately; after release, a new push of tag=7 is broadcast normally.
